// File: rtl/decoder_4_if.sv
// ---------------------------------------------------------------------------
// decoder_4_if
// Serial bus bundle for the decoder_4 pattern detector.
//   sig  : serial data stream (driver -> detector)
//   prgm : serial pattern-programming stream, MSB first (driver -> detector)
//   out  : match indication (detector -> driver)
// master : the stream driver (drives sig/prgm, observes out)
// slave  : the detector (samples sig/prgm, drives out)
// ---------------------------------------------------------------------------
interface decoder_4_if;
    logic sig;
    logic prgm;
    logic out;

    modport master (
        output sig,
        output prgm,
        input  out
    );

    modport slave (
        input  sig,
        input  prgm,
        output out
    );
endinterface

// File: rtl/decoder_4.sv
// ---------------------------------------------------------------------------
// decoder_4
// Serial-programmable 4-bit pattern detector.
// After clr the first four prgm bits (MSB first) are shifted into the
// pattern register, which then locks until the next clr. In parallel, sig is
// shifted into a 4-bit window on every edge; out is high whenever both the
// pattern and the window are full and equal.
//
// Ports:
//   clk  : sole clock, rising edge
//   clr  : synchronous active-high reset; wins over any shifting on its edge
//   bus  : decoder_4_if.slave (sig / prgm in, out out)
// ---------------------------------------------------------------------------
module decoder_4 (
    input  logic          clk,
    input  logic          clr,
    decoder_4_if.slave    bus
);

    localparam logic [2:0] FULL = 3'd4;

    logic [3:0] r_pat;   // pattern; first programmed bit ends in r_pat[3]
    logic [2:0] r_pcnt;  // program bits taken, saturates at FULL
    logic [3:0] r_win;   // window; r_win[3] oldest, r_win[0] newest
    logic [2:0] r_wcnt;  // window bits taken, saturates at FULL

    logic w_pat_lock;
    logic w_win_full;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pat  <= 4'd0;
            r_pcnt <= 3'd0;
            r_win  <= 4'd0;
            r_wcnt <= 3'd0;
        end else begin
            r_win <= {r_win[2:0], bus.sig};
            if (r_wcnt != FULL)
                r_wcnt <= r_wcnt + 3'd1;
            // Programming runs concurrently with the window; once four bits
            // are in, prgm is ignored until the next clr.
            if (r_pcnt != FULL) begin
                r_pat  <= {r_pat[2:0], bus.prgm};
                r_pcnt <= r_pcnt + 3'd1;
            end
        end
    end

    assign w_pat_lock = (r_pcnt == FULL);
    assign w_win_full = (r_wcnt == FULL);

    // Registers only: no combinational path from sig/prgm to out.
    assign bus.out = w_pat_lock & w_win_full & (r_win == r_pat);

endmodule

// File: tb/tb_decoder_4.sv
module tb_decoder_4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    decoder_4_if dif();

    decoder_4 dut (
        .clk (clk),
        .clr (clr),
        .bus (dif)
    );

    // Reference: bit histories since the last clr.
    logic sig_q[$];
    logic prg_q[$];
    logic exp_q[$];
    string name_q[$];

    int tests  = 0;
    int fails  = 0;
    string phase = "init";

    function automatic logic model_out();
        int n;
        logic m;
        n = sig_q.size();
        if (prg_q.size() < 4 || n < 4) return 1'b0;
        m = 1'b1;
        for (int k = 0; k < 4; k++)
            if (sig_q[n - 4 + k] !== prg_q[k]) m = 1'b0;
        return m;
    endfunction

    // Drive one cycle on the falling edge and queue the expected out for
    // the rising edge that follows.
    task automatic step(input logic c, input logic s, input logic p);
        @(negedge clk);
        clr      = c;
        dif.sig  = s;
        dif.prgm = p;
        if (c) begin
            sig_q.delete();
            prg_q.delete();
        end else begin
            sig_q.push_back(s);
            if (prg_q.size() < 4) prg_q.push_back(p);
        end
        exp_q.push_back(model_out());
        name_q.push_back(phase);
    endtask

    // sig/prgm vectors applied MSB first over n edges with clr low.
    task automatic run(input logic [15:0] s, input logic [15:0] p, input int n);
        for (int k = n - 1; k >= 0; k--)
            step(1'b0, s[k], p[k]);
    endtask

    // Monitor: compare every cycle the DUT output just after the edge.
    initial begin
        logic e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests++;
                if (dif.out !== e) begin
                    fails++;
                    $display("FAIL %s @%0t: out=%b expected=%b", nm, $time, dif.out, e);
                end
            end
        end
    end

    initial begin
        clr = 1'b1;
        dif.sig = 1'b0;
        dif.prgm = 1'b0;

        // Reset hold with toggling inputs
        phase = "reset_hold";
        for (int k = 0; k < 3; k++) step(1'b1, k[0], ~k[0]);

        // Program 1010, scan 1010000101000000 -> hits after edges 4 and 11
        phase = "prog_scan";
        run(16'b1010000101000000, 16'b1010_1111_0000_0101, 16);

        // Pattern lock: program 0110, then prgm held 1 while sig = 0110
        phase = "lock";
        step(1'b1, 1'b0, 1'b0);
        run(16'h0001, 16'h0006, 4);
        run(16'h0006, 16'h000F, 4);
        run(16'h0096, 16'h00FF, 8);

        // Overlap: pattern 0101, sig 010101 -> hits after edges 4 and 6
        phase = "overlap";
        step(1'b1, 1'b1, 1'b1);
        run(16'b010101, 16'b010111, 6);

        // Continuous: pattern 1111, sig held 1
        phase = "continuous";
        step(1'b1, 1'b0, 1'b0);
        run(16'hFFFF, 16'hFFFF, 12);

        // Mid-stream reset while out=1, then program 0000 with sig=0
        phase = "mid_reset";
        step(1'b1, 1'b1, 1'b1);
        run(16'h0000, 16'h0000, 6);

        // Randomized traffic with occasional clr
        phase = "random";
        for (int k = 0; k < 2000; k++)
            step(($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom));

        // Drain: every queued expectation must have been consumed
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
